// File: rtl/conv_sched.sv
// conv_sched: frame scheduler between the FWFT feature FIFO and the conv datapath.
// Pops one pixel per accepted handshake and emits a line-buffer write for each one.
// It issues a MACC start whenever a full KxK window is resident.
// After the last window it flushes the MACC pipeline for MACC_LAT cycles, then pulses o_done.
// Optional build macro: CONV_SCHED_PERF_EN enables the backpressure stall counter on o_stall_cnt.
module conv_sched #(
   parameter int unsigned IMG_W    = 32,
   parameter int unsigned IMG_H    = 32,
   parameter int unsigned K        = 5,
   parameter int unsigned MACC_LAT = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_start,
   input  logic                           i_feature_valid,
   output logic                           o_rd_en,
   input  logic                           i_out_ready,
   output logic                           o_wr_en,
   output logic [$clog2(IMG_H)-1:0]       o_wr_row,
   output logic [$clog2(IMG_W)-1:0]       o_wr_col,
   output logic                           o_macc_en,
   output logic [$clog2(IMG_H-K+1)-1:0]   o_win_row,
   output logic [$clog2(IMG_W-K+1)-1:0]   o_win_col,
   output logic                           o_last_win,
   output logic                           o_busy,
   output logic                           o_done,
   output logic [15:0]                    o_stall_cnt
);

   localparam int unsigned RW  = $clog2(IMG_H);
   localparam int unsigned CW  = $clog2(IMG_W);
   localparam int unsigned WRW = $clog2(IMG_H-K+1);
   localparam int unsigned WCW = $clog2(IMG_W-K+1);
   localparam int unsigned FW  = $clog2(MACC_LAT+1);

   typedef enum logic [1:0] {StIdle, StFill, StConv, StFlush} state_e;

   state_e           state_q, state_d;
   logic [RW-1:0]    row_q, row_d;
   logic [CW-1:0]    col_q, col_d;
   logic [FW-1:0]    flush_q, flush_d;
   logic             wr_en_q, wr_en_d;
   logic [RW-1:0]    wr_row_q, wr_row_d;
   logic [CW-1:0]    wr_col_q, wr_col_d;
   logic             macc_en_q, macc_en_d;
   logic [WRW-1:0]   win_row_q, win_row_d;
   logic [WCW-1:0]   win_col_q, win_col_d;
   logic             last_win_q, last_win_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic accept;
   logic start_ok;
   logic col_last;
   logic row_last;
   logic fill_end;

   // Pop is decoded from the state register; only CONV is throttled by downstream ready.
   assign o_rd_en  = (state_q == StFill) || ((state_q == StConv) && i_out_ready);
   assign accept   = o_rd_en && i_feature_valid;
   // A start coinciding with o_done is ignored; the block is only idle from the next cycle.
   assign start_ok = (state_q == StIdle) && !done_q && i_start;
   assign col_last = (col_q == CW'(IMG_W-1));
   assign row_last = (row_q == RW'(IMG_H-1));
   assign fill_end = (row_q == RW'(K-2)) && col_last;

   // Next-state and next-output logic for the frame FSM.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      flush_d    = flush_q;
      wr_en_d    = 1'b0;
      wr_row_d   = wr_row_q;
      wr_col_d   = wr_col_q;
      macc_en_d  = 1'b0;
      win_row_d  = win_row_q;
      win_col_d  = win_col_q;
      last_win_d = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;

      // Busy covers the o_done cycle itself and drops right after it.
      if (done_q) begin
         busy_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d = StFill;
               row_d   = '0;
               col_d   = '0;
               busy_d  = 1'b1;
            end
         end
         StFill, StConv: begin
            if (accept) begin
               wr_en_d  = 1'b1;
               wr_row_d = row_q;
               wr_col_d = col_q;
               if (col_last) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (state_q == StFill) begin
                  if (fill_end) begin
                     state_d = StConv;
                  end
               end else begin
                  // Rows 0..K-1 are resident once in CONV; columns gate the window.
                  if (col_q >= CW'(K-1)) begin
                     macc_en_d = 1'b1;
                     win_row_d = WRW'(row_q - RW'(K-1));
                     win_col_d = WCW'(col_q - CW'(K-1));
                  end
                  if (row_last && col_last) begin
                     last_win_d = 1'b1;
                     row_d      = '0;
                     flush_d    = '0;
                     state_d    = StFlush;
                  end
               end
            end
         end
         StFlush: begin
            if (flush_q == FW'(MACC_LAT-1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               flush_d = flush_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and registered outputs; reset returns everything to idle immediately.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= StIdle;
         row_q      <= '0;
         col_q      <= '0;
         flush_q    <= '0;
         wr_en_q    <= 1'b0;
         wr_row_q   <= '0;
         wr_col_q   <= '0;
         macc_en_q  <= 1'b0;
         win_row_q  <= '0;
         win_col_q  <= '0;
         last_win_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         flush_q    <= flush_d;
         wr_en_q    <= wr_en_d;
         wr_row_q   <= wr_row_d;
         wr_col_q   <= wr_col_d;
         macc_en_q  <= macc_en_d;
         win_row_q  <= win_row_d;
         win_col_q  <= win_col_d;
         last_win_q <= last_win_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign o_wr_en    = wr_en_q;
   assign o_wr_row   = wr_row_q;
   assign o_wr_col   = wr_col_q;
   assign o_macc_en  = macc_en_q;
   assign o_win_row  = win_row_q;
   assign o_win_col  = win_col_q;
   assign o_last_win = last_win_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

`ifdef CONV_SCHED_PERF_EN
   logic [15:0] stall_q, stall_d;

   // Saturating count of CONV cycles where a pixel waits only on downstream ready.
   always_comb begin
      stall_d = stall_q;
      if (start_ok) begin
         stall_d = '0;
      end else if ((state_q == StConv) && i_feature_valid && !i_out_ready &&
                   (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // Stall counter register; holds its value after o_done until the next start.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign o_stall_cnt = stall_q;
`else
   assign o_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Directed self-checking bench for conv_sched at default parameters (32x32, K=5, MACC_LAT=4).
module tb_conv_sched;

   logic        clk;
   logic        rst;
   logic        start;
   logic        valid;
   logic        rd_en;
   logic        ready;
   logic        wr_en;
   logic [4:0]  wr_row;
   logic [4:0]  wr_col;
   logic        macc_en;
   logic [4:0]  win_row;
   logic [4:0]  win_col;
   logic        last_win;
   logic        busy;
   logic        done;
   logic [15:0] stall_cnt;

`ifdef CONV_SCHED_PERF_EN
   localparam int ExpStall = 10;
`else
   localparam int ExpStall = 0;
`endif

   conv_sched dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_start         (start),
      .i_feature_valid (valid),
      .o_rd_en         (rd_en),
      .i_out_ready     (ready),
      .o_wr_en         (wr_en),
      .o_wr_row        (wr_row),
      .o_wr_col        (wr_col),
      .o_macc_en       (macc_en),
      .o_win_row       (win_row),
      .o_win_col       (win_col),
      .o_last_win      (last_win),
      .o_busy          (busy),
      .o_done          (done),
      .o_stall_cnt     (stall_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: expected raster order, window coordinates and last flag per write beat.
   int         exp_r = 0, exp_c = 0, wr_cnt = 0, macc_cnt = 0, mon_err = 0, lw_cyc = 0;
   logic       busy_prev = 1'b0, first_seen = 1'b0, last_seen = 1'b0;
   logic       m331 = 1'b1, m40 = 1'b1;
   logic [4:0] first_wr_r = '0, first_wr_c = '0, first_win_r = '0, first_win_c = '0;
   logic [4:0] lw_r = '0, lw_c = '0;

   function automatic int beat_errs(input int r, input int c, input logic [4:0] wr_r,
                                    input logic [4:0] wr_c, input logic [4:0] wn_r,
                                    input logic [4:0] wn_c, input logic me, input logic lw);
      int   e;
      logic exp_me;
      logic exp_lw;
      e      = 0;
      exp_me = (r >= 4) && (c >= 4);
      exp_lw = (r == 31) && (c == 31);
      if (wr_r !== 5'(r) || wr_c !== 5'(c)) e++;
      if (me !== exp_me) e++;
      if (exp_me && (wn_r !== 5'(r - 4) || wn_c !== 5'(c - 4))) e++;
      if (lw !== exp_lw) e++;
      return e;
   endfunction

   always @(negedge clk) begin
      busy_prev <= busy;
      if (busy === 1'b1 && busy_prev !== 1'b1) begin
         exp_r      <= 0;
         exp_c      <= 0;
         wr_cnt     <= 0;
         macc_cnt   <= 0;
         mon_err    <= 0;
         first_seen <= 1'b0;
         last_seen  <= 1'b0;
         m331       <= 1'b1;
         m40        <= 1'b1;
      end else if (wr_en === 1'b1) begin
         mon_err <= mon_err + beat_errs(exp_r, exp_c, wr_row, wr_col, win_row, win_col,
                                        macc_en, last_win);
         if (exp_c == 31) begin
            exp_c <= 0;
            exp_r <= exp_r + 1;
         end else begin
            exp_c <= exp_c + 1;
         end
         wr_cnt <= wr_cnt + 1;
         if (wr_row == 5'd3 && wr_col == 5'd31) m331 <= macc_en;
         if (wr_row == 5'd4 && wr_col == 5'd0) m40 <= macc_en;
         if (macc_en === 1'b1) begin
            macc_cnt <= macc_cnt + 1;
            if (!first_seen) begin
               first_seen  <= 1'b1;
               first_wr_r  <= wr_row;
               first_wr_c  <= wr_col;
               first_win_r <= win_row;
               first_win_c <= win_col;
            end
         end
         if (last_win === 1'b1) begin
            last_seen <= 1'b1;
            lw_cyc    <= cyc;
            lw_r      <= win_row;
            lw_c      <= win_col;
         end
      end else if (macc_en !== 1'b0 || last_win !== 1'b0) begin
         mon_err <= mon_err + 1;
      end
   end

   int n_assert = 0;
   int n_fail   = 0;
   int done_cyc;
   bit done_ok;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outs(input string p);
      chk({p, "_rd_en"}, 32'(rd_en), 0);
      chk({p, "_wr_en"}, 32'(wr_en), 0);
      chk({p, "_macc_en"}, 32'(macc_en), 0);
      chk({p, "_last_win"}, 32'(last_win), 0);
      chk({p, "_busy"}, 32'(busy), 0);
      chk({p, "_done"}, 32'(done), 0);
      chk({p, "_wr_row"}, 32'(wr_row), 0);
      chk({p, "_wr_col"}, 32'(wr_col), 0);
      chk({p, "_win_row"}, 32'(win_row), 0);
      chk({p, "_win_col"}, 32'(win_col), 0);
      chk({p, "_stall"}, 32'(stall_cnt), 0);
   endtask

   task automatic start_frame(input string p);
      @(posedge clk); #1;
      start = 1'b1;
      @(negedge clk);
      chk({p, "_idle_rd_en"}, 32'(rd_en), 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({p, "_fill_rd_en"}, 32'(rd_en), 1);
      chk({p, "_busy_set"}, 32'(busy), 1);
      chk({p, "_stall_clr"}, 32'(stall_cnt), 0);
   endtask

   // Runs to o_done; optional input bubbles, a 10-cycle backpressure window and a stray start.
   task automatic run_frame(input string p, input bit bubbles, input int bp_at,
                            input int start_at);
      bit pulsed;
      bit bp_done;
      pulsed  = 1'b0;
      bp_done = 1'b0;
      done_ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (bubbles) valid = ($urandom_range(0, 99) >= 30);
         if (start_at >= 0 && !pulsed && wr_cnt >= start_at) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         if (bp_at >= 0 && !bp_done && wr_cnt >= bp_at) begin
            bp_done = 1'b1;
            ready   = 1'b0;
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               chk({p, "_bp_rd_en"}, 32'(rd_en), 0);
               if (k > 0) chk({p, "_bp_wr_en"}, 32'(wr_en), 0);
               if (k > 0) chk({p, "_bp_macc"}, 32'(macc_en), 0);
               if (k < 9) begin
                  @(posedge clk); #1;
               end
            end
            @(posedge clk); #1;
            ready = 1'b1;
            @(negedge clk);
            chk({p, "_bp_end_wr_en"}, 32'(wr_en), 0);
            chk({p, "_bp_end_rd_en"}, 32'(rd_en), 1);
            continue;
         end
         @(negedge clk);
         if (done === 1'b1) begin
            done_cyc = cyc;
            done_ok  = 1'b1;
            break;
         end
      end
      chk({p, "_done_seen"}, 32'(done_ok), 1);
      chk({p, "_busy_at_done"}, 32'(busy), 1);
      chk({p, "_rd_en_at_done"}, 32'(rd_en), 0);
      #1;
      chk({p, "_writes"}, 32'(wr_cnt), 1024);
      chk({p, "_maccs"}, 32'(macc_cnt), 784);
      chk({p, "_seq_errs"}, 32'(mon_err), 0);
      chk({p, "_first_wr_row"}, 32'(first_wr_r), 4);
      chk({p, "_first_wr_col"}, 32'(first_wr_c), 4);
      chk({p, "_first_win"}, {27'd0, first_win_r} | 32'(first_win_c), 0);
      chk({p, "_last_seen"}, 32'(last_seen), 1);
      chk({p, "_last_win_row"}, 32'(lw_r), 27);
      chk({p, "_last_win_col"}, 32'(lw_c), 27);
      chk({p, "_done_latency"}, 32'(done_cyc - lw_cyc), 4);
      chk({p, "_macc_at_3_31"}, 32'(m331), 0);
      chk({p, "_macc_at_4_0"}, 32'(m40), 0);
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      valid = 1'b1;
      ready = 1'b1;
      #5 rst = 1'b1;
      #5;
      chk_reset_outs("por");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Nominal frame with a stray start mid-CONV, then a start on the o_done cycle.
      start_frame("nom");
      run_frame("nom", 1'b0, -1, 600);
      chk("nom_stall", 32'(stall_cnt), 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("done_start_busy", 32'(busy), 0);
      chk("done_start_rd_en", 32'(rd_en), 0);
      @(negedge clk);
      chk("done_start_still_idle", 32'(rd_en), 0);

      // Backpressure frame.
      start_frame("bp");
      run_frame("bp", 1'b0, 300, -1);
      chk("bp_stall_at_done", 32'(stall_cnt), ExpStall);
      repeat (3) @(negedge clk);
      chk("bp_stall_held", 32'(stall_cnt), ExpStall);

      // Bubble frame: same counts and raster order with 30% invalid cycles.
      start_frame("bub");
      run_frame("bub", 1'b1, -1, -1);
      valid = 1'b1;

      // Reset after 500 accepts, then a clean frame.
      start_frame("rst");
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk); #1;
         if (wr_cnt >= 500) break;
      end
      chk("rst_reached_500", 32'(wr_cnt), 500);
      rst = 1'b1;
      #1;
      chk_reset_outs("mid");
      @(posedge clk); #1;
      rst = 1'b0;
      start_frame("post");
      run_frame("post", 1'b0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
